// File: rtl/sodor_dmem_arbiter.sv
// Preloads the sodor5 data memory after reset, then shares its single
// port round-robin between the core dmem port and a debug port.
//
// Ports:
//   clk, reset      clock, async active-low reset
//   init_req        pulse: re-run the preload from RUN
//   init_done       high while in RUN
//   core_req_*      core word request (byte address, wr, wdata)
//   core_resp_*     core response, one cycle after grant
//   dbg_req_*       debug request, same shape as core
//   dbg_resp_*      debug response, same shape as core
//   mem_*           single-ported synchronous memory
`timescale 1ns/1ps
module sodor_dmem_arbiter #(
  parameter int unsigned       ADDR_W       = 4,
  parameter int unsigned       DATA_W       = 32,
  parameter logic [DATA_W-1:0] INIT_PATTERN = 32'h11111111
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              init_req,
  output logic              init_done,
  input  logic              core_req_valid,
  output logic              core_req_ready,
  input  logic [31:0]       core_req_addr,
  input  logic              core_req_wr,
  input  logic [DATA_W-1:0] core_req_wdata,
  output logic              core_resp_valid,
  output logic [DATA_W-1:0] core_resp_data,
  input  logic              dbg_req_valid,
  output logic              dbg_req_ready,
  input  logic [31:0]       dbg_req_addr,
  input  logic              dbg_req_wr,
  input  logic [DATA_W-1:0] dbg_req_wdata,
  output logic              dbg_resp_valid,
  output logic [DATA_W-1:0] dbg_resp_data,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned PW    = ADDR_W + DATA_W;

  typedef enum logic {
    INIT,
    RUN
  } state_t;

  typedef enum logic {
    CORE,
    DBG
  } port_t;

  state_t            state_q;
  state_t            state_nx;
  port_t             last_q;
  port_t             last_nx;
  logic [ADDR_W-1:0] cnt_q;
  logic [ADDR_W-1:0] cnt_nx;

  logic              core_pend_q;
  logic              dbg_pend_q;
  logic              rd_q;
  logic [DATA_W-1:0] core_data_q;
  logic [DATA_W-1:0] dbg_data_q;

  logic              core_sel;
  logic              dbg_sel;
  logic              grant;
  logic [29:0]       sel_word;
  logic              sel_wr;
  logic [DATA_W-1:0] sel_wdata;
  logic              in_range;
  logic [DATA_W-1:0] rdata_sel;

  logic [DATA_W-1:0] preload_data;
  logic [ADDR_W-1:0] unused_prod_hi;
  logic              unused_lsb;

  assign {unused_prod_hi, preload_data} =
    PW'(cnt_q) * PW'(INIT_PATTERN);

  // Byte offset is ignored: word accesses only.
  assign unused_lsb = ^{core_req_addr[1:0],
                        dbg_req_addr[1:0]};

  always_comb begin
    core_sel = 1'b0;
    dbg_sel  = 1'b0;
    if (state_q == RUN) begin
      unique case (1'b1)
        core_req_valid && dbg_req_valid: begin
          if (last_q == DBG) core_sel = 1'b1;
          else               dbg_sel  = 1'b1;
        end
        core_req_valid && !dbg_req_valid:
          core_sel = 1'b1;
        !core_req_valid && dbg_req_valid:
          dbg_sel = 1'b1;
        default: ;
      endcase
    end
  end

  assign grant = core_sel | dbg_sel;

  always_comb begin
    sel_word  = core_req_addr[31:2];
    sel_wr    = core_req_wr;
    sel_wdata = core_req_wdata;
    if (dbg_sel) begin
      sel_word  = dbg_req_addr[31:2];
      sel_wr    = dbg_req_wr;
      sel_wdata = dbg_req_wdata;
    end
  end

  assign in_range = (sel_word[29:ADDR_W] == '0);

  assign core_req_ready = core_sel;
  assign dbg_req_ready  = dbg_sel;
  assign init_done      = (state_q == RUN);

  // INIT drives the memory from the state alone, so the live reset
  // level gates it to keep mem_* at 0 while reset is held.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (reset) begin
      unique case (1'b1)
        state_q == INIT: begin
          mem_en    = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = cnt_q;
          mem_wdata = preload_data;
        end
        (state_q == RUN) && grant && in_range: begin
          mem_en    = 1'b1;
          mem_we    = sel_wr;
          mem_addr  = sel_word[ADDR_W-1:0];
          mem_wdata = sel_wdata;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx = state_q;
    cnt_nx   = cnt_q;
    last_nx  = last_q;
    unique case (state_q)
      INIT: begin
        cnt_nx = cnt_q + 1'b1;
        if (cnt_q == ADDR_W'(DEPTH - 1)) begin
          state_nx = RUN;
          cnt_nx   = '0;
        end
      end
      RUN: begin
        if (init_req) begin
          state_nx = INIT;
          cnt_nx   = '0;
        end
      end
      default: state_nx = INIT;
    endcase
    if (core_sel)     last_nx = CORE;
    else if (dbg_sel) last_nx = DBG;
  end

  // Reads return memory data; writes and dropped accesses return 0.
  assign rdata_sel = rd_q ? mem_rdata : '0;

  assign core_resp_valid = core_pend_q;
  assign dbg_resp_valid  = dbg_pend_q;
  assign core_resp_data  = core_pend_q ? rdata_sel
                                       : core_data_q;
  assign dbg_resp_data   = dbg_pend_q ? rdata_sel
                                      : dbg_data_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= INIT;
      cnt_q       <= '0;
      last_q      <= DBG;
      core_pend_q <= 1'b0;
      dbg_pend_q  <= 1'b0;
      rd_q        <= 1'b0;
      core_data_q <= '0;
      dbg_data_q  <= '0;
    end else begin
      state_q     <= state_nx;
      cnt_q       <= cnt_nx;
      last_q      <= last_nx;
      core_pend_q <= core_sel;
      dbg_pend_q  <= dbg_sel;
      rd_q        <= grant && in_range && !sel_wr;
      if (core_pend_q) core_data_q <= core_resp_data;
      if (dbg_pend_q)  dbg_data_q  <= dbg_resp_data;
    end
  end

endmodule

// File: tb/tb_sodor_dmem_arbiter.sv
// Bench for sodor_dmem_arbiter: behavioural memory, directed stimulus,
// response scoreboard checked by an independent monitor.
`timescale 1ns/1ps
module tb_sodor_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        init_req;
  logic        init_done;
  logic        core_req_valid;
  logic        core_req_ready;
  logic [31:0] core_req_addr;
  logic        core_req_wr;
  logic [31:0] core_req_wdata;
  logic        core_resp_valid;
  logic [31:0] core_resp_data;
  logic        dbg_req_valid;
  logic        dbg_req_ready;
  logic [31:0] dbg_req_addr;
  logic        dbg_req_wr;
  logic [31:0] dbg_req_wdata;
  logic        dbg_resp_valid;
  logic [31:0] dbg_resp_data;
  logic        mem_en;
  logic        mem_we;
  logic [3:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem [16];

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_core [$];
  logic [31:0] exp_dbg  [$];

  always #5 clk = ~clk;

  sodor_dmem_arbiter dut (
    .clk             (clk),
    .reset           (reset),
    .init_req        (init_req),
    .init_done       (init_done),
    .core_req_valid  (core_req_valid),
    .core_req_ready  (core_req_ready),
    .core_req_addr   (core_req_addr),
    .core_req_wr     (core_req_wr),
    .core_req_wdata  (core_req_wdata),
    .core_resp_valid (core_resp_valid),
    .core_resp_data  (core_resp_data),
    .dbg_req_valid   (dbg_req_valid),
    .dbg_req_ready   (dbg_req_ready),
    .dbg_req_addr    (dbg_req_addr),
    .dbg_req_wr      (dbg_req_wr),
    .dbg_req_wdata   (dbg_req_wdata),
    .dbg_resp_valid  (dbg_resp_valid),
    .dbg_resp_data   (dbg_resp_data),
    .mem_en          (mem_en),
    .mem_we          (mem_we),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .mem_rdata       (mem_rdata)
  );

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h",
               nm, act, exp);
    end
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_ctl"},
        {25'd0, core_req_ready, dbg_req_ready,
         core_resp_valid, dbg_resp_valid,
         init_done, mem_en, mem_we}, 32'h0);
    chk({nm, "_core_data"}, core_resp_data, 32'h0);
    chk({nm, "_dbg_data"}, dbg_resp_data, 32'h0);
    chk({nm, "_mem_addr"}, {28'd0, mem_addr}, 32'h0);
    chk({nm, "_mem_wdata"}, mem_wdata, 32'h0);
  endtask

  task automatic run_init(input bit pulse);
    for (int i = 0; i < 16; i++) begin
      init_req       = pulse && (i == 5);
      core_req_valid = 1'b1;
      core_req_addr  = 32'h0;
      core_req_wr    = 1'b0;
      dbg_req_valid  = 1'b1;
      dbg_req_addr   = 32'h4;
      dbg_req_wr     = 1'b0;
      #1;
      chk("init_en", {31'd0, mem_en}, 32'h1);
      chk("init_we", {31'd0, mem_we}, 32'h1);
      chk("init_addr", {28'd0, mem_addr}, i);
      chk("init_wdata", mem_wdata, i * 32'h11111111);
      chk("init_core_ready", {31'd0, core_req_ready}, 32'h0);
      chk("init_dbg_ready", {31'd0, dbg_req_ready}, 32'h0);
      chk("init_done_low", {31'd0, init_done}, 32'h0);
      @(negedge clk);
    end
    init_req       = 1'b0;
    core_req_valid = 1'b0;
    dbg_req_valid  = 1'b0;
    #1;
    chk("init_done_high", {31'd0, init_done}, 32'h1);
    chk("run_idle_en", {31'd0, mem_en}, 32'h0);
  endtask

  // Response monitor: pops one expectation per presented response.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (core_resp_valid) begin
        if (exp_core.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL core_resp_unexpected: got 0x%08h, expected none",
                   core_resp_data);
        end else begin
          e = exp_core.pop_front();
          chk("core_resp_data", core_resp_data, e);
        end
      end
      if (dbg_resp_valid) begin
        if (exp_dbg.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL dbg_resp_unexpected: got 0x%08h, expected none",
                   dbg_resp_data);
        end else begin
          e = exp_dbg.pop_front();
          chk("dbg_resp_data", dbg_resp_data, e);
        end
      end
    end
  end

  initial begin
    #200000;
    n_checks++;
    n_fail++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  initial begin
    reset          = 1'b0;
    init_req       = 1'b0;
    core_req_valid = 1'b0;
    core_req_addr  = 32'h0;
    core_req_wr    = 1'b0;
    core_req_wdata = 32'h0;
    dbg_req_valid  = 1'b0;
    dbg_req_addr   = 32'h0;
    dbg_req_wr     = 1'b0;
    dbg_req_wdata  = 32'h0;

    @(negedge clk);
    #1;
    chk_zero("reset");

    @(negedge clk);
    reset = 1'b1;
    run_init(1'b1);

    core_req_valid = 1'b1;
    core_req_addr  = 32'h28;
    #1;
    chk("rd10_core_ready", {31'd0, core_req_ready}, 32'h1);
    chk("rd10_dbg_ready", {31'd0, dbg_req_ready}, 32'h0);
    chk("rd10_mem_en", {31'd0, mem_en}, 32'h1);
    chk("rd10_mem_we", {31'd0, mem_we}, 32'h0);
    chk("rd10_mem_addr", {28'd0, mem_addr}, 32'd10);
    exp_core.push_back(32'hAAAAAAAA);
    @(negedge clk);
    core_req_valid = 1'b0;
    #1;
    chk("rd10_core_valid", {31'd0, core_resp_valid}, 32'h1);
    chk("rd10_dbg_valid", {31'd0, dbg_resp_valid}, 32'h0);

    dbg_req_valid = 1'b1;
    dbg_req_addr  = 32'h8;
    #1;
    chk("rd2_dbg_ready", {31'd0, dbg_req_ready}, 32'h1);
    chk("rd2_mem_addr", {28'd0, mem_addr}, 32'd2);
    exp_dbg.push_back(32'h22222222);
    @(negedge clk);

    for (int k = 0; k < 4; k++) begin
      core_req_valid = 1'b1;
      core_req_addr  = 32'h4;
      dbg_req_valid  = 1'b1;
      dbg_req_addr   = 32'h8;
      #1;
      chk("rr_core_ready", {31'd0, core_req_ready},
          (k % 2 == 0) ? 32'h1 : 32'h0);
      chk("rr_dbg_ready", {31'd0, dbg_req_ready},
          (k % 2 == 1) ? 32'h1 : 32'h0);
      chk("rr_mem_addr", {28'd0, mem_addr},
          (k % 2 == 0) ? 32'd1 : 32'd2);
      if (k % 2 == 0) exp_core.push_back(32'h11111111);
      else            exp_dbg.push_back(32'h22222222);
      @(negedge clk);
    end
    core_req_valid = 1'b0;
    dbg_req_valid  = 1'b0;

    core_req_valid = 1'b1;
    core_req_addr  = 32'h3C;
    core_req_wr    = 1'b1;
    core_req_wdata = 32'hDEADBEEF;
    #1;
    chk("wr15_ready", {31'd0, core_req_ready}, 32'h1);
    chk("wr15_mem_we", {31'd0, mem_we}, 32'h1);
    chk("wr15_mem_addr", {28'd0, mem_addr}, 32'd15);
    chk("wr15_mem_wdata", mem_wdata, 32'hDEADBEEF);
    exp_core.push_back(32'h0);
    @(negedge clk);
    core_req_wr    = 1'b0;
    core_req_wdata = 32'h0;
    #1;
    chk("rd15_ready", {31'd0, core_req_ready}, 32'h1);
    chk("rd15_mem_we", {31'd0, mem_we}, 32'h0);
    exp_core.push_back(32'hDEADBEEF);
    @(negedge clk);
    core_req_valid = 1'b0;
    #1;
    chk("idle_mem_en", {31'd0, mem_en}, 32'h0);
    chk("idle_mem_addr", {28'd0, mem_addr}, 32'h0);
    @(negedge clk);
    #1;
    chk("hold_valid", {31'd0, core_resp_valid}, 32'h0);
    chk("hold_data", core_resp_data, 32'hDEADBEEF);

    core_req_valid = 1'b1;
    core_req_addr  = 32'h40;
    #1;
    chk("oor_ready", {31'd0, core_req_ready}, 32'h1);
    chk("oor_mem_en", {31'd0, mem_en}, 32'h0);
    chk("oor_mem_addr", {28'd0, mem_addr}, 32'h0);
    chk("oor_mem_wdata", mem_wdata, 32'h0);
    exp_core.push_back(32'h0);
    @(negedge clk);
    core_req_valid = 1'b0;
    #1;
    chk("oor_resp_valid", {31'd0, core_resp_valid}, 32'h1);

    dbg_req_valid = 1'b1;
    dbg_req_addr  = 32'h3C;
    init_req      = 1'b1;
    #1;
    chk("reinit_dbg_ready", {31'd0, dbg_req_ready}, 32'h1);
    chk("reinit_done_still", {31'd0, init_done}, 32'h1);
    exp_dbg.push_back(32'hDEADBEEF);
    @(negedge clk);
    init_req      = 1'b0;
    dbg_req_valid = 1'b0;
    run_init(1'b0);

    dbg_req_valid = 1'b1;
    dbg_req_addr  = 32'h3C;
    #1;
    chk("w15_restored_ready", {31'd0, dbg_req_ready}, 32'h1);
    exp_dbg.push_back(32'hFFFFFFFF);
    @(negedge clk);
    dbg_req_valid = 1'b0;

    core_req_valid = 1'b1;
    core_req_addr  = 32'hC;
    #1;
    chk("prerst_core_ready", {31'd0, core_req_ready}, 32'h1);
    #2;
    reset          = 1'b0;
    core_req_valid = 1'b0;
    #1;
    chk_zero("rst_async");
    @(negedge clk);
    #1;
    chk_zero("rst_hold");
    @(negedge clk);
    reset = 1'b1;
    run_init(1'b0);

    core_req_valid = 1'b1;
    core_req_addr  = 32'hC;
    #1;
    exp_core.push_back(32'h33333333);
    @(negedge clk);
    core_req_valid = 1'b0;

    repeat (3) @(negedge clk);
    #3;
    chk("core_q_empty", exp_core.size(), 32'h0);
    chk("dbg_q_empty", exp_dbg.size(), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
